// File: rtl/nn_mac_vector_unit.sv
// nn_mac_vector_unit: LANES-wide signed multiply-accumulate neuron.
// Each beat carries LANES weight/input pairs. The products are registered
// (P1), reduced to one beat partial (P2) and added into the accumulator
// (P3). When the vector's last beat leaves P3, the clamped result is loaded
// into the output register. One vector is in flight at a time.
// Optional build macro: NN_MAC_RELU_EN (ReLU after saturation).

// Per-lane multiplier: one full-precision signed product, registered.
module nn_mac_lane #(
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       en,
  input  logic signed [DATA_W-1:0]   w,
  input  logic signed [DATA_W-1:0]   x,
  output logic signed [2*DATA_W-1:0] prod
);
  // Capture the product when a beat is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prod <= '0;
    else if (en)  prod <= w * x;
  end
endmodule

module nn_mac_vector_unit #(
  parameter int LANES  = 4,
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16,
  parameter int ACC_W  = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic [LANES*DATA_W-1:0]   weights,
  input  logic [LANES*DATA_W-1:0]   inputs,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_W-1:0]          out_data,
  output logic                      out_sat
);
  localparam int PROD_W = 2 * DATA_W;
  // vld_pipe[0]: products valid, [1]: partial valid, [2]: accumulator updated
  localparam int STAGES = 2;

  localparam logic [1:0] ACCUM  = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] OUTPUT = 2'd2;

  localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [1:0]                     state;
  logic                           accept;
  logic                           fin;
  logic [STAGES:0]                vld_pipe;
  logic [STAGES:0]                last_pipe;
  logic [LANES-1:0][PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]        psum;
  logic signed [ACC_W-1:0]        partial;
  logic signed [ACC_W-1:0]        acc;
  logic                           sat_hi;
  logic                           sat_lo;
  logic [OUT_W-1:0]               clamped;
  logic [OUT_W-1:0]               result;

  assign in_ready  = reset_n && (state == ACCUM);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == OUTPUT);
  // Final sum sits in acc once the last beat has cleared P3.
  assign fin       = vld_pipe[STAGES] && last_pipe[STAGES];

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      nn_mac_lane #(.DATA_W(DATA_W)) u_lane (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (accept),
        .w       (weights[g*DATA_W +: DATA_W]),
        .x       (inputs[g*DATA_W +: DATA_W]),
        .prod    (prod[g])
      );
    end
  endgenerate

  // Sign-extend every product to ACC_W and reduce to one beat partial.
  always_comb begin
    psum = '0;
    for (int l = 0; l < LANES; l++)
      psum = psum + {{(ACC_W-PROD_W){prod[l][PROD_W-1]}}, prod[l]};
  end

  // Beat valid / last flags travel alongside the data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:0], accept};
      last_pipe <= {last_pipe[STAGES-1:0], accept && in_last};
    end
  end

  // P2 partial register and P3 accumulator; acc clears as the result loads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      partial <= '0;
      acc     <= '0;
    end else begin
      if (vld_pipe[0]) partial <= psum;
      if (fin)              acc <= '0;
      else if (vld_pipe[1]) acc <= acc + partial;
    end
  end

  // Clamp the accumulator into the OUT_W signed range.
  always_comb begin
    sat_hi  = acc > SMAX;
    sat_lo  = acc < SMIN;
    clamped = acc[OUT_W-1:0];
    if (sat_hi)      clamped = {1'b0, {(OUT_W-1){1'b1}}};
    else if (sat_lo) clamped = {1'b1, {(OUT_W-1){1'b0}}};
  end

`ifdef NN_MAC_RELU_EN
  // Negative results are zeroed after saturation; out_sat is unaffected.
  always_comb begin
    result = clamped[OUT_W-1] ? '0 : clamped;
  end
`else
  // Plain signed saturated output.
  always_comb begin
    result = clamped;
  end
`endif

  // Output register holds its value from load until the next load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data <= '0;
      out_sat  <= 1'b0;
    end else if (fin) begin
      out_data <= result;
      out_sat  <= sat_hi || sat_lo;
    end
  end

  // Vector framing: accumulate, drain the pipeline, hold the result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ACCUM;
    else begin
      case (state)
        ACCUM:   if (accept && in_last) state <= DRAIN;
        DRAIN:   if (fin)               state <= OUTPUT;
        OUTPUT:  if (out_ready)         state <= ACCUM;
        default:                        state <= ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_nn_mac_vector_unit.sv
// Scoreboard bench for nn_mac_vector_unit (default parameters).
// Stimulus pushes the hand-computed result of each vector; the monitor
// pops and compares on every output handshake.
module tb_nn_mac_vector_unit;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, in_last;
  logic [31:0] weights, inputs;
  logic        out_valid, out_ready;
  logic [15:0] out_data;
  logic        out_sat;

  typedef struct { int data; bit sat; } exp_t;
  exp_t sb[$];
  int nvec = 0;
  int nerr = 0;

`ifdef NN_MAC_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  nn_mac_vector_unit dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .weights(weights), .inputs(inputs),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    logic [7:0] a8, b8, c8, d8;
    a8 = a[7:0]; b8 = b[7:0]; c8 = c[7:0]; d8 = d[7:0];
    return {d8, c8, b8, a8};
  endfunction

  function automatic int relu(input int d);
    return (RELU && d < 0) ? 0 : d;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_out(input int d, input bit s);
    exp_t e;
    e.data = relu(d);
    e.sat  = s;
    sb.push_back(e);
  endtask

  // Present a beat from just after a posedge; returns #1 after its accept edge.
  task automatic beat(input logic [31:0] w, input logic [31:0] x, input logic last);
    int n = 0;
    in_valid = 1'b1; weights = w; inputs = x; in_last = last;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      nvec++; nerr++;
      $display("FAIL accept_timeout: in_ready stuck at 0");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    chk(name, sb.size(), 0);
  endtask

  // Monitor: compare on each output handshake.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected_out: got %0d with nothing expected", $signed(out_data));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", int'($signed(out_data)), e.data);
        chk("out_sat", int'(out_sat), int'(e.sat));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    weights = '0; inputs = '0; out_ready = 1'b1;
    #12;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_sat", int'(out_sat), 0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", int'(in_ready), 1);

    // Single beat: 6 - 4 - 10 + 6 = -2, latency three edges.
    expect_out(-2, 1'b0);
    beat(pk(2, -1, 5, 1), pk(3, 4, -2, 6), 1'b1);
    chk("t1_drain_in_ready", int'(in_ready), 0);
    @(posedge clk); #1; chk("t1_valid_k1", int'(out_valid), 0);
    @(posedge clk); #1; chk("t1_valid_k2", int'(out_valid), 0);
    @(posedge clk); #1; chk("t1_valid_k3", int'(out_valid), 1);
    wait_empty("t1_drained");

    // Three beats of 100 each.
    expect_out(300, 1'b0);
    beat(pk(1, 1, 1, 1), pk(10, 20, 30, 40), 1'b0);
    beat(pk(1, 1, 1, 1), pk(10, 20, 30, 40), 1'b0);
    beat(pk(1, 1, 1, 1), pk(10, 20, 30, 40), 1'b1);
    chk("t2_in_ready_after_last", int'(in_ready), 0);
    @(posedge clk); #1; chk("t2_in_ready_drain", int'(in_ready), 0);
    wait_empty("t2_drained");

    // Positive saturation: 2 * 4 * 16129 = 129032.
    expect_out(32767, 1'b1);
    beat(pk(127, 127, 127, 127), pk(127, 127, 127, 127), 1'b0);
    beat(pk(127, 127, 127, 127), pk(127, 127, 127, 127), 1'b1);
    wait_empty("t3_drained");

    // Negative saturation: 2 * 4 * -16256 = -130048.
    expect_out(-32768, 1'b1);
    beat(pk(-128, -128, -128, -128), pk(127, 127, 127, 127), 1'b0);
    beat(pk(-128, -128, -128, -128), pk(127, 127, 127, 127), 1'b1);
    wait_empty("t4_drained");

    // Backpressure: 1+2+3+4 = 10 held while out_ready is low.
    out_ready = 1'b0;
    expect_out(10, 1'b0);
    beat(pk(1, 2, 3, 4), pk(1, 1, 1, 1), 1'b1);
    begin
      int n = 0;
      while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    end
    chk("t5_valid_arrives", int'(out_valid), 1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("t5_hold_valid", int'(out_valid), 1);
      chk("t5_hold_data", int'($signed(out_data)), 10);
      chk("t5_hold_sat", int'(out_sat), 0);
      chk("t5_hold_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t5_valid_fall", int'(out_valid), 0);
    chk("t5_in_ready_back", int'(in_ready), 1);
    chk("t5_sb_popped", sb.size(), 0);
    // Next vector from a cleared accumulator: -1-2-3-4 = -10.
    expect_out(-10, 1'b0);
    beat(pk(1, 1, 1, 1), pk(-1, -2, -3, -4), 1'b1);
    wait_empty("t5b_drained");

    // Reset mid-vector discards the partial sum.
    beat(pk(7, 7, 7, 7), pk(9, 9, 9, 9), 1'b0);
    beat(pk(7, 7, 7, 7), pk(9, 9, 9, 9), 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", int'(out_valid), 0);
    chk("t6_rst_out_data", int'(out_data), 0);
    chk("t6_rst_out_sat", int'(out_sat), 0);
    chk("t6_rst_in_ready", int'(in_ready), 0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    expect_out(5, 1'b0);
    beat(pk(1, 0, 0, 0), pk(5, 0, 0, 0), 1'b1);
    wait_empty("t6_drained");

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
